// File: rtl/id_ex_decode_unit.sv
// ARM decode stage with a registered ID/EX boundary and a 2-cycle Rs sequencer.
// Define ID_THIRD_READ_PORT_EN to read Rs on a third port and issue three-source ops in one cycle.
module id_ex_decode_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int REG_COUNT  = 16,
    parameter int CMD_WIDTH  = 4,
    localparam int REG_ADDR_WIDTH = $clog2(REG_COUNT)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      instr_valid,
    input  logic [ADDR_WIDTH-1:0]     pc_in,
    input  logic [31:0]               instr_in,
    input  logic [3:0]                status_in,
    input  logic                      wb_en,
    input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    input  logic                      hazard,
    input  logic                      flush,
    output logic                      id_stall,
    output logic                      ex_valid,
    output logic                      ex_mem_read,
    output logic                      ex_mem_write,
    output logic                      ex_wb_en,
    output logic                      ex_imm,
    output logic                      ex_branch,
    output logic                      ex_s,
    output logic [CMD_WIDTH-1:0]      ex_cmd,
    output logic [ADDR_WIDTH-1:0]     ex_pc,
    output logic [DATA_WIDTH-1:0]     ex_rn_val,
    output logic [DATA_WIDTH-1:0]     ex_rm_val,
    output logic [DATA_WIDTH-1:0]     ex_rs_val,
    output logic [REG_ADDR_WIDTH-1:0] ex_dest,
    output logic [REG_ADDR_WIDTH-1:0] ex_src1,
    output logic [REG_ADDR_WIDTH-1:0] ex_src2,
    output logic [11:0]               ex_shift_operand,
    output logic [23:0]               ex_signed_imm
);

`ifdef ID_THIRD_READ_PORT_EN
    localparam bit SEQ_EN = 1'b0;
`else
    localparam bit SEQ_EN = 1'b1;
`endif

    typedef enum logic [0:0] {DECODE, RS_READ} state_t;

    state_t                    state_reg, state_next;
    logic [DATA_WIDTH-1:0]     regs [REG_COUNT];
    logic [DATA_WIDTH-1:0]     lat_rn_reg, lat_rm_reg;
    logic [DATA_WIDTH-1:0]     rn_rd, rm_rd, rs_rd;
    logic [REG_ADDR_WIDTH-1:0] src1, src2, rs_addr;
    logic [1:0]                mode;
    logic [3:0]                opcode;
    logic                      is_store, three_src, cond_ok;
    logic [CMD_WIDTH-1:0]      d_cmd;
    logic                      d_mem_read, d_mem_write, d_wb_en, d_branch, d_s;
    logic                      do_issue, from_latch, latch_en, stall_c;

    generate
        for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_regs
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    regs[gi] <= '0;
                else if (wb_en && wb_addr == REG_ADDR_WIDTH'(gi))
                    regs[gi] <= wb_data;
            end
        end
    endgenerate

    assign mode      = instr_in[27:26];
    assign opcode    = instr_in[24:21];
    assign is_store  = (mode == 2'b01) && !instr_in[20];
    assign src1      = instr_in[19:16];
    assign src2      = is_store ? instr_in[15:12] : instr_in[3:0];
    assign rs_addr   = instr_in[11:8];
    assign three_src = (mode == 2'b00) && !instr_in[25] && instr_in[4] && !instr_in[7];

    // Write-through reads: a same-cycle writeback is visible immediately.
    assign rn_rd = (wb_en && wb_addr == src1)    ? wb_data : regs[src1];
    assign rm_rd = (wb_en && wb_addr == src2)    ? wb_data : regs[src2];
    assign rs_rd = (wb_en && wb_addr == rs_addr) ? wb_data : regs[rs_addr];

    always_comb begin
        d_cmd       = '0;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
        d_wb_en     = 1'b0;
        d_branch    = 1'b0;
        d_s         = 1'b0;
        case (mode)
            2'b00: begin
                d_wb_en = 1'b1;
                d_s     = instr_in[20];
                case (opcode)
                    4'b1101: d_cmd = CMD_WIDTH'(4'b0001);
                    4'b1111: d_cmd = CMD_WIDTH'(4'b1001);
                    4'b0100: d_cmd = CMD_WIDTH'(4'b0010);
                    4'b0101: d_cmd = CMD_WIDTH'(4'b0011);
                    4'b0010: d_cmd = CMD_WIDTH'(4'b0100);
                    4'b0110: d_cmd = CMD_WIDTH'(4'b0101);
                    4'b0000: d_cmd = CMD_WIDTH'(4'b0110);
                    4'b1100: d_cmd = CMD_WIDTH'(4'b0111);
                    4'b0001: d_cmd = CMD_WIDTH'(4'b1000);
                    4'b1010: begin
                        d_cmd   = CMD_WIDTH'(4'b0100);
                        d_wb_en = 1'b0;
                        d_s     = 1'b1;
                    end
                    4'b1000: begin
                        d_cmd   = CMD_WIDTH'(4'b0110);
                        d_wb_en = 1'b0;
                        d_s     = 1'b1;
                    end
                    default: d_cmd = '0;
                endcase
            end
            2'b01: begin
                d_cmd       = CMD_WIDTH'(4'b0010);
                d_mem_read  = instr_in[20];
                d_wb_en     = instr_in[20];
                d_mem_write = !instr_in[20];
            end
            2'b10:   d_branch = 1'b1;
            default: d_cmd = '0;
        endcase
    end

    always_comb begin
        case (instr_in[31:28])
            4'b0000: cond_ok = status_in[2];
            4'b0001: cond_ok = !status_in[2];
            4'b0010: cond_ok = status_in[1];
            4'b0011: cond_ok = !status_in[1];
            4'b0100: cond_ok = status_in[3];
            4'b0101: cond_ok = !status_in[3];
            4'b0110: cond_ok = status_in[0];
            4'b0111: cond_ok = !status_in[0];
            4'b1000: cond_ok = status_in[1] && !status_in[2];
            4'b1001: cond_ok = !status_in[1] || status_in[2];
            4'b1010: cond_ok = status_in[3] == status_in[0];
            4'b1011: cond_ok = status_in[3] != status_in[0];
            4'b1100: cond_ok = !status_in[2] && (status_in[3] == status_in[0]);
            4'b1101: cond_ok = status_in[2] || (status_in[3] != status_in[0]);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        do_issue   = 1'b0;
        from_latch = 1'b0;
        latch_en   = 1'b0;
        stall_c    = 1'b0;
        state_next = state_reg;
        case (state_reg)
            DECODE: begin
                if (flush) begin
                    stall_c = 1'b0;
                end else if (hazard) begin
                    stall_c = 1'b1;
                end else if (instr_valid && cond_ok) begin
                    if (three_src && SEQ_EN) begin
                        latch_en   = 1'b1;
                        stall_c    = 1'b1;
                        state_next = RS_READ;
                    end else begin
                        do_issue = 1'b1;
                    end
                end
            end
            RS_READ: begin
                if (flush) begin
                    state_next = DECODE;
                end else if (hazard) begin
                    // Refresh Rn/Rm while held so writebacks during the stall are not lost.
                    stall_c  = 1'b1;
                    latch_en = 1'b1;
                end else begin
                    do_issue   = 1'b1;
                    from_latch = 1'b1;
                    state_next = DECODE;
                end
            end
            default: state_next = DECODE;
        endcase
    end

    assign id_stall = stall_c && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= DECODE;
            lat_rn_reg       <= '0;
            lat_rm_reg       <= '0;
            ex_valid         <= 1'b0;
            ex_mem_read      <= 1'b0;
            ex_mem_write     <= 1'b0;
            ex_wb_en         <= 1'b0;
            ex_imm           <= 1'b0;
            ex_branch        <= 1'b0;
            ex_s             <= 1'b0;
            ex_cmd           <= '0;
            ex_pc            <= '0;
            ex_rn_val        <= '0;
            ex_rm_val        <= '0;
            ex_rs_val        <= '0;
            ex_dest          <= '0;
            ex_src1          <= '0;
            ex_src2          <= '0;
            ex_shift_operand <= '0;
            ex_signed_imm    <= '0;
        end else begin
            state_reg <= state_next;
            if (latch_en) begin
                lat_rn_reg <= rn_rd;
                lat_rm_reg <= rm_rd;
            end
            ex_valid     <= do_issue;
            ex_mem_read  <= do_issue && d_mem_read;
            ex_mem_write <= do_issue && d_mem_write;
            ex_wb_en     <= do_issue && d_wb_en;
            ex_imm       <= do_issue && instr_in[25];
            ex_branch    <= do_issue && d_branch;
            ex_s         <= do_issue && d_s;
            ex_cmd       <= do_issue ? d_cmd : '0;
            // Data fields hold across bubbles; they change only on an issue.
            if (do_issue) begin
                ex_pc            <= pc_in;
                ex_rn_val        <= from_latch ? lat_rn_reg : rn_rd;
                ex_rm_val        <= from_latch ? lat_rm_reg : rm_rd;
                ex_rs_val        <= (from_latch || !SEQ_EN) ? rs_rd : '0;
                ex_dest          <= instr_in[15:12];
                ex_src1          <= src1;
                ex_src2          <= src2;
                ex_shift_operand <= instr_in[11:0];
                ex_signed_imm    <= instr_in[23:0];
            end
        end
    end

endmodule

// File: tb/tb_id_ex_decode_unit.sv
// Randomised bench for id_ex_decode_unit against an instruction-level reference model.
// Honours ID_THIRD_READ_PORT_EN the same way the design does.
module tb_id_ex_decode_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] pc_in = '0;
    logic [31:0] instr_in = '0;
    logic [3:0]  status_in = '0;
    logic        wb_en = 1'b0;
    logic [3:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        hazard = 1'b0;
    logic        flush = 1'b0;
    logic        id_stall, ex_valid, ex_mem_read, ex_mem_write, ex_wb_en, ex_imm, ex_branch, ex_s;
    logic [3:0]  ex_cmd;
    logic [31:0] ex_pc, ex_rn_val, ex_rm_val, ex_rs_val;
    logic [3:0]  ex_dest, ex_src1, ex_src2;
    logic [11:0] ex_shift_operand;
    logic [23:0] ex_signed_imm;

    always #5 clk = ~clk;

    id_ex_decode_unit dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .pc_in(pc_in), .instr_in(instr_in),
        .status_in(status_in), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .hazard(hazard), .flush(flush), .id_stall(id_stall), .ex_valid(ex_valid),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_wb_en(ex_wb_en),
        .ex_imm(ex_imm), .ex_branch(ex_branch), .ex_s(ex_s), .ex_cmd(ex_cmd), .ex_pc(ex_pc),
        .ex_rn_val(ex_rn_val), .ex_rm_val(ex_rm_val), .ex_rs_val(ex_rs_val),
        .ex_dest(ex_dest), .ex_src1(ex_src1), .ex_src2(ex_src2),
        .ex_shift_operand(ex_shift_operand), .ex_signed_imm(ex_signed_imm)
    );

`ifdef ID_THIRD_READ_PORT_EN
    localparam bit SEQ = 1'b0;
`else
    localparam bit SEQ = 1'b1;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] m_regs [16];
    logic [3:0]  cmd_tab [16];
    bit          m_wait, m_rs_chk, g_stall;
    logic [31:0] m_lrn, m_lrm;
    logic        e_valid, e_mr, e_mw, e_wb, e_imm, e_br, e_s;
    logic [3:0]  e_cmd, e_dest, e_src1, e_src2;
    logic [31:0] e_pc, e_rn, e_rm, e_rs;
    logic [11:0] e_shift;
    logic [23:0] e_simm;
    int          ops [11] = '{13, 15, 4, 5, 2, 10, 6, 0, 8, 12, 1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ARM conditions come in complementary pairs; the low bit inverts the base test.
    function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] st);
        bit n = st[3], z = st[2], cf = st[1], v = st[0], base;
        if (c == 4'd14) return 1'b1;
        if (c == 4'd15) return 1'b0;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            default: base = !z && (n == v);
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic logic [31:0] rdv(input logic [3:0] a);
        return (wb_en && wb_addr == a) ? wb_data : m_regs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_wait = 0; m_rs_chk = 0; g_stall = 0; m_lrn = '0; m_lrm = '0;
        {e_valid, e_mr, e_mw, e_wb, e_imm, e_br, e_s} = '0;
        e_cmd = '0; e_dest = '0; e_src1 = '0; e_src2 = '0;
        e_pc = '0; e_rn = '0; e_rm = '0; e_rs = '0; e_shift = '0; e_simm = '0;
    endtask

    // One clock: entered just after a negedge with inputs driven, leaves at the next negedge.
    task automatic run_cycle();
        logic [31:0] i = instr_in;
        logic [1:0]  mode = i[27:26];
        int          op = int'(i[24:21]);
        bit          store = (mode == 2'd1) && !i[20];
        bit          nodest = (op == 10) || (op == 8);
        logic [3:0]  s2 = store ? i[15:12] : i[3:0];
        logic [31:0] rn = rdv(i[19:16]), rm = rdv(s2), rs = rdv(i[11:8]);
        bit three = (mode == 2'd0) && !i[25] && i[4] && !i[7];
        bit issue = 0, lat = 0, use_lat = 0, stall = 0;
        #1;
        if (!m_wait) begin
            if (flush) ;
            else if (hazard) stall = 1;
            else if (instr_valid && cond_pass(i[31:28], status_in)) begin
                if (three && SEQ) begin lat = 1; stall = 1; m_wait = 1; end
                else issue = 1;
            end
        end else begin
            if (flush) m_wait = 0;
            else if (hazard) begin stall = 1; lat = 1; end
            else begin issue = 1; use_lat = 1; m_wait = 0; end
        end
        check("id_stall", 32'(id_stall), 32'(stall));
        g_stall = stall;
        @(posedge clk);
        e_valid = issue;
        e_mr  = issue && mode == 2'd1 && i[20];
        e_mw  = issue && store;
        e_wb  = issue && ((mode == 2'd0 && !nodest) || (mode == 2'd1 && i[20]));
        e_imm = issue && i[25];
        e_br  = issue && mode == 2'd2;
        e_s   = issue && mode == 2'd0 && (nodest || i[20]);
        e_cmd = !issue ? 4'd0 : (mode == 2'd0) ? cmd_tab[op] : (mode == 2'd1) ? 4'd2 : 4'd0;
        if (issue) begin
            e_pc = pc_in; e_dest = i[15:12]; e_src1 = i[19:16]; e_src2 = s2;
            e_shift = i[11:0]; e_simm = i[23:0];
            e_rn = use_lat ? m_lrn : rn;
            e_rm = use_lat ? m_lrm : rm;
            e_rs = rs;
            m_rs_chk = three;
        end
        if (lat) begin m_lrn = rn; m_lrm = rm; end
        if (wb_en) m_regs[wb_addr] = wb_data;
        #1;
        check("ex_valid", 32'(ex_valid), 32'(e_valid));
        check("ex_mem_read", 32'(ex_mem_read), 32'(e_mr));
        check("ex_mem_write", 32'(ex_mem_write), 32'(e_mw));
        check("ex_wb_en", 32'(ex_wb_en), 32'(e_wb));
        check("ex_imm", 32'(ex_imm), 32'(e_imm));
        check("ex_branch", 32'(ex_branch), 32'(e_br));
        check("ex_s", 32'(ex_s), 32'(e_s));
        check("ex_cmd", 32'(ex_cmd), 32'(e_cmd));
        check("ex_pc", ex_pc, e_pc);
        check("ex_rn_val", ex_rn_val, e_rn);
        check("ex_rm_val", ex_rm_val, e_rm);
        if (m_rs_chk) check("ex_rs_val", ex_rs_val, e_rs);
        check("ex_dest", 32'(ex_dest), 32'(e_dest));
        check("ex_src1", 32'(ex_src1), 32'(e_src1));
        check("ex_src2", 32'(ex_src2), 32'(e_src2));
        check("ex_shift_operand", 32'(ex_shift_operand), 32'(e_shift));
        check("ex_signed_imm", 32'(ex_signed_imm), 32'(e_simm));
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [3:0] st, input bit we, input logic [3:0] wa,
                         input logic [31:0] wd, input bit hz, input bit fl);
        instr_valid = v; instr_in = ins; pc_in = pc; status_in = st;
        wb_en = we; wb_addr = wa; wb_data = wd; hazard = hz; flush = fl;
        run_cycle();
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        drive(0, 32'h0, 32'h0, 4'h0, 1, a, d, 0, 0);
    endtask

    initial begin
        logic [31:0] ins, pc;
        bit v;
        for (int k = 0; k < 16; k++) cmd_tab[k] = 4'd0;
        cmd_tab[13] = 4'd1; cmd_tab[15] = 4'd9; cmd_tab[4] = 4'd2;  cmd_tab[5] = 4'd3;
        cmd_tab[2]  = 4'd4; cmd_tab[10] = 4'd4; cmd_tab[6] = 4'd5;  cmd_tab[0] = 4'd6;
        cmd_tab[8]  = 4'd6; cmd_tab[12] = 4'd7; cmd_tab[1] = 4'd8;
        model_reset();
        #2 rst = 1'b1;
        @(negedge clk); @(negedge clk);
        check("reset_valid", 32'(ex_valid), 32'd0);
        check("reset_cmd", 32'(ex_cmd), 32'd0);
        check("reset_stall", 32'(id_stall), 32'd0);
        rst = 1'b0;

        wr(4'd2, 32'd5);
        wr(4'd3, 32'd7);
        drive(1, 32'hE0821003, 32'h100, 4'h0, 0, 0, 0, 0, 0);
        check("add_cmd", 32'(ex_cmd), 32'd2);
        check("add_rn", ex_rn_val, 32'd5);
        check("add_rm", ex_rm_val, 32'd7);
        check("add_dest", 32'(ex_dest), 32'd1);
        check("add_valid", 32'(ex_valid), 32'd1);

        drive(1, 32'h00821003, 32'h104, 4'b0000, 0, 0, 0, 0, 0);
        check("addeq_z0_valid", 32'(ex_valid), 32'd0);
        check("addeq_z0_wb", 32'(ex_wb_en), 32'd0);
        drive(1, 32'h00821003, 32'h108, 4'b0100, 0, 0, 0, 0, 0);
        check("addeq_z1_valid", 32'(ex_valid), 32'd1);

        drive(1, 32'hE0821003, 32'h10C, 4'h0, 1, 4'd2, 32'd9, 0, 0);
        check("bypass_rn", ex_rn_val, 32'd9);

        wr(4'd1, 32'd1); wr(4'd2, 32'd2); wr(4'd3, 32'd3);
        drive(1, 32'hE0810312, 32'h110, 4'h0, 0, 0, 0, 0, 0);
        check("rsr_stall1", 32'(g_stall), 32'(SEQ));
        if (SEQ) drive(1, 32'hE0810312, 32'h110, 4'h0, 0, 0, 0, 0, 0);
        check("rsr_stall2", 32'(g_stall), 32'd0);
        check("rsr_valid", 32'(ex_valid), 32'd1);
        check("rsr_rs", ex_rs_val, 32'd3);
        check("rsr_rn", ex_rn_val, 32'd1);
        check("rsr_rm", ex_rm_val, 32'd2);

        drive(1, 32'hE0810312, 32'h114, 4'h0, 0, 0, 0, 0, 0);
        drive(1, 32'hE0810312, 32'h114, 4'h0, 0, 0, 0, 0, 1);
        check("flush_valid", 32'(ex_valid), 32'd0);
        drive(1, 32'hE0821003, 32'h118, 4'h0, 0, 0, 0, 0, 0);
        check("post_flush_valid", 32'(ex_valid), 32'd1);
        check("post_flush_rn", ex_rn_val, 32'd2);

        for (int k = 0; k < 3; k++) begin
            drive(1, 32'hE5854000, 32'h11C, 4'h0, 0, 0, 0, 1, 0);
            check("haz_stall", 32'(g_stall), 32'd1);
            check("haz_valid", 32'(ex_valid), 32'd0);
        end
        drive(1, 32'hE5854000, 32'h11C, 4'h0, 0, 0, 0, 0, 0);
        check("str_mem_write", 32'(ex_mem_write), 32'd1);
        check("str_src2", 32'(ex_src2), 32'd4);

        ins = '0; pc = 32'h200; v = 0;
        for (int n = 0; n < 1500; n++) begin
            if (n == 700) begin
                hazard = 1'b1;
                #2 rst = 1'b1;
                #1;
                check("async_rst_valid", 32'(ex_valid), 32'd0);
                check("async_rst_cmd", 32'(ex_cmd), 32'd0);
                check("async_rst_stall", 32'(id_stall), 32'd0);
                model_reset();
                @(negedge clk);
                rst = 1'b0;
            end
            if (!g_stall) begin
                ins = $urandom;
                ins[31:28] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd14;
                ins[27:26] = 2'($urandom_range(0, 2));
                if (ins[27:26] == 2'd0) ins[24:21] = 4'(ops[$urandom_range(0, 10)]);
                if ($urandom_range(0, 1) == 1) begin ins[25] = 0; ins[4] = 1; ins[7] = 0; end
                v = ($urandom_range(0, 9) != 0);
                pc = pc + 32'd4;
            end
            drive(v, ins, pc, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 6) == 0,
                  $urandom_range(0, 9) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/id_ex_decode_unit.md
Name: id_ex_decode_unit

Overview:
- Parametrised next-generation ARM decode stage with an integrated, registered ID/EX pipeline boundary.
- Decodes the instruction, checks its condition code and reads the register file.
- Adds valid/stall/flush handling and a 2-cycle sequencer for register-shifted-register operands (Rn, Rm, Rs) on a 2-read-port register file.
- Sits between the IF/ID register and the EX stage; drives stall back to IF.

Parameters:
- DATA_WIDTH, 32, register/operand width.
- ADDR_WIDTH, 32, PC width.
- REG_COUNT, 16, architectural registers; REG_ADDR_WIDTH = clog2(REG_COUNT).
- CMD_WIDTH, 4, execute command width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  IF/ID holds a real instruction.
- pc_in  in  ADDR_WIDTH  PC of instruction.
- instr_in  in  32  instruction word.
- status_in  in  4  {N,Z,C,V}.
- wb_en, wb_addr, wb_data  in  1/REG_ADDR_WIDTH/DATA_WIDTH  writeback port.
- hazard  in  1  hazard unit stall request.
- flush  in  1  branch taken in EX; kill ID contents.
- id_stall  out  1  hold PC and IF/ID.
- ex_valid, ex_mem_read, ex_mem_write, ex_wb_en, ex_imm, ex_branch, ex_s  out  1 each  registered controls.
- ex_cmd  out  CMD_WIDTH  execute command.
- ex_pc  out  ADDR_WIDTH.
- ex_rn_val, ex_rm_val, ex_rs_val  out  DATA_WIDTH  operand values.
- ex_dest, ex_src1, ex_src2  out  REG_ADDR_WIDTH  Rd, Rn, second source (for forwarding).
- ex_shift_operand  out  12.
- ex_signed_imm  out  24.

Behaviour:
- Reset: every ex_* output is 0, id_stall is 0, FSM is in DECODE, and all register file entries are 0.
- Decode, mode = instr[27:26]:
  - Mode 00 (data processing), cmd by opcode[24:21]: MOV→0001, MVN→1001, ADD→0010, ADC→0011, SUB/CMP→0100, SBC→0101, AND/TST→0110, ORR→0111, EOR→1000.
  - CMP/TST: wb_en=0, s=1.
  - Mode 01 (memory): cmd=0010; instr[20]=1 is load (mem_read, wb_en), instr[20]=0 is store (mem_write).
  - Mode 10: branch=1.
  - ex_imm = instr[25].
- Source registers:
  - src1 = instr[19:16].
  - src2 = instr[15:12] for a store, else instr[3:0].
  - Rs = instr[11:8].
- Register file:
  - Written on the rising edge when wb_en is high.
  - Reads are write-through: a read of wb_addr in the same cycle as the write returns wb_data.
- Condition check: standard ARM cond[31:28] against status_in; 1110 = always; 1111 = never.
- Bubble: ex_valid and all control outputs are 0; data outputs hold their previous values.
- Issue: all ex_* outputs loaded together; ex_valid=1.
- Three-source condition: mode 00, instr[25]=0, instr[4]=1, instr[7]=0.
- FSM, one issue per cycle otherwise:
  - DECODE:
    - flush: bubble, stay in DECODE.
    - hazard: bubble, id_stall=1, stay.
    - !instr_valid, or condition fails: bubble, no stall.
    - Three-source: latch Rn/Rm values, id_stall=1, bubble, go to RS_READ.
    - Otherwise: issue.
  - RS_READ:
    - Port 2 reads Rs.
    - flush: bubble, discard latched values, go to DECODE.
    - hazard: bubble, id_stall=1, stay; the latched Rn/Rm are re-read (refreshed) to pick up writebacks.
    - Otherwise: issue using the latched Rn/Rm and the current Rs, id_stall=0, go to DECODE.
- Latency: 1 cycle from IF/ID to EX; 2 cycles for three-source instructions.
- Simultaneous flush and hazard: flush wins.
- Reset asserted mid-sequence returns the FSM to DECODE immediately.

Optional Feature:
ID_THIRD_READ_PORT_EN
- Defined: the register file has a third read port for Rs. Three-source instructions issue in 1 cycle, RS_READ is never entered, and id_stall equals hazard & ~flush.
- Undefined: 2-read-port file with the 2-cycle sequencer above.

Test Plan:
- rst high mid-stream → ex_valid=0, ex_cmd=0, id_stall=0 asynchronously; after release, ADD R1,R2,R3 (E0821003) with R2=5, R3=7 → next cycle ex_cmd=0010, ex_rn_val=5, ex_rm_val=7, ex_dest=1, ex_valid=1.
- Condition check: ADDEQ with Z=0 → bubble (ex_wb_en=0, ex_valid=0); the same instruction with Z=1 → issue.
- Writeback bypass: wb_en=1, wb_addr=2, wb_data=9 in the same cycle as decoding ADD R1,R2,R3 → ex_rn_val=9.
- Three-source sequence: ADD R0,R1,R2,LSL R3 (E0810312) with R1=1, R2=2, R3=3:
  - Without the macro: id_stall=1 for one cycle, then ex_rs_val=3, ex_rn_val=1, ex_rm_val=2.
  - With the macro: no stall.
- Flush in RS_READ → ex_valid=0 and FSM back in DECODE; the next instruction issues normally.
- Hazard held 3 cycles on a STR → 3 bubbles, id_stall=1 throughout, then ex_mem_write=1 and ex_src2 = instr[15:12].
